buff_scanout_ctrl: RTL

//  Downstream read side of the ping-pong pixel buffers (buffer 0 / buffer 1, 24-bit RGB each).

---
 rtl/display_pkg.sv | 33 +++
 rtl/disp_timing_gen.sv | 58 +++++
 rtl/buff_scanout_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared display scan-out definitions: timing defaults, FSM encoding, pixel payload.
package display_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned RGB_W = 3 * PIX_W;

  localparam int unsigned H_ACTIVE_DEF = 100;
  localparam int unsigned H_FP_DEF     = 4;
  localparam int unsigned H_SYNC_DEF   = 8;
  localparam int unsigned H_BP_DEF     = 4;
  localparam int unsigned V_ACTIVE_DEF = 100;
  localparam int unsigned V_FP_DEF     = 2;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 2;
  localparam int unsigned ADDR_W_DEF   = 20;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  // Counter width able to hold the value 'total' itself (so end-of-range compares never truncate).
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total > 1) ? $clog2(total + 1) : 1;
  endfunction

endpackage

// File: rtl/disp_timing_gen.sv
// Raster position counters and the region flags decoded from them.
module disp_timing_gen
  import display_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  output logic active_c,
  output logic hsync_c,
  output logic vsync_c,
  output logic frame_last_c
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = cnt_width(H_TOTAL);
  localparam int unsigned V_W     = cnt_width(V_TOTAL);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           h_last_c;
  logic           v_last_c;

  assign h_last_c = (h_cnt == H_W'(H_TOTAL - 1));
  assign v_last_c = (v_cnt == V_W'(V_TOTAL - 1));

  // Position counters; they only move while the scan is consuming positions.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (advance) begin
      if (h_last_c) begin
        h_cnt <= '0;
        v_cnt <= v_last_c ? '0 : v_cnt + V_W'(1);
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
    end
  end

  assign active_c     = (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
  assign hsync_c      = (h_cnt >= H_W'(H_ACTIVE + H_FP)) &&
                        (h_cnt <  H_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_c      = (v_cnt >= V_W'(V_ACTIVE + V_FP)) &&
                        (v_cnt <  V_W'(V_ACTIVE + V_FP + V_SYNC));
  assign frame_last_c = h_last_c && v_last_c;

endmodule

// File: rtl/buff_scanout_ctrl.sv
// Read side of the ping-pong pixel buffers: raster timing, buffer reads, swap control, RGB realign.
module buff_scanout_ctrl
  import display_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              rd_sel,
  output logic              re0,
  output logic              re1,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  r0,
  input  logic [PIX_W-1:0]  g0,
  input  logic [PIX_W-1:0]  b0,
  input  logic [PIX_W-1:0]  r1,
  input  logic [PIX_W-1:0]  g1,
  input  logic [PIX_W-1:0]  b1,
  output logic [PIX_W-1:0]  pix_r,
  output logic [PIX_W-1:0]  pix_g,
  output logic [PIX_W-1:0]  pix_b,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_done
);

  scan_state_t       state;
  scan_state_t       state_nxt;
  logic              advance_c;
  logic              read_c;
  logic              active_c;
  logic              hsync_c;
  logic              vsync_c;
  logic              frame_last_c;

  logic [ADDR_W-1:0] pix_idx;
  logic [ADDR_W-1:0] pix_idx_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic              re0_nxt;
  logic              re1_nxt;
  logic              rd_sel_nxt;
  logic              swap_ack_nxt;
  logic              frame_done_nxt;
  logic              de_a_nxt;
  logic              hs_a_nxt;
  logic              vs_a_nxt;

  // Read-issue stage flags and the selected buffer, waiting one clock for the data.
  logic              de_a;
  logic              hs_a;
  logic              vs_a;
  logic              rd_sel_d;

  rgb_t              rgb0_c;
  rgb_t              rgb1_c;
  rgb_t              pix_c;

  disp_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk          (clk),
    .reset        (reset),
    .advance      (advance_c),
    .active_c     (active_c),
    .hsync_c      (hsync_c),
    .vsync_c      (vsync_c),
    .frame_last_c (frame_last_c)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus next values of every registered output of the read-issue stage.
  always_comb begin
    state_nxt      = state;
    advance_c      = 1'b0;
    read_c         = 1'b0;
    pix_idx_nxt    = pix_idx;
    rd_addr_nxt    = rd_addr;
    re0_nxt        = 1'b0;
    re1_nxt        = 1'b0;
    rd_sel_nxt     = rd_sel;
    swap_ack_nxt   = 1'b0;
    frame_done_nxt = 1'b0;
    de_a_nxt       = 1'b0;
    hs_a_nxt       = 1'b0;
    vs_a_nxt       = 1'b0;

    // An enabled IDLE already consumes position 0 so the first read issues without a bubble.
    case (state)
      ST_IDLE: begin
        if (enable) begin
          advance_c = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        advance_c = 1'b1;
        if (frame_last_c && !enable) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (advance_c) begin
      read_c   = active_c;
      de_a_nxt = active_c;
      hs_a_nxt = hsync_c;
      vs_a_nxt = vsync_c;
      re0_nxt  = read_c && !rd_sel;
      re1_nxt  = read_c &&  rd_sel;
      if (read_c) begin
        rd_addr_nxt = pix_idx;
        pix_idx_nxt = pix_idx + ADDR_W'(1);
      end
      // Frame end is always blanking, so the toggle never lands under an active read.
      if (frame_last_c) begin
        pix_idx_nxt    = '0;
        frame_done_nxt = 1'b1;
        swap_ack_nxt   = swap_req;
        rd_sel_nxt     = rd_sel ^ swap_req;
      end
    end else begin
      rd_addr_nxt = '0;
    end
  end

  // Read-issue stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_idx    <= '0;
      rd_addr    <= '0;
      re0        <= 1'b0;
      re1        <= 1'b0;
      rd_sel     <= 1'b0;
      swap_ack   <= 1'b0;
      frame_done <= 1'b0;
      de_a       <= 1'b0;
      hs_a       <= 1'b0;
      vs_a       <= 1'b0;
    end else begin
      pix_idx    <= pix_idx_nxt;
      rd_addr    <= rd_addr_nxt;
      re0        <= re0_nxt;
      re1        <= re1_nxt;
      rd_sel     <= rd_sel_nxt;
      swap_ack   <= swap_ack_nxt;
      frame_done <= frame_done_nxt;
      de_a       <= de_a_nxt;
      hs_a       <= hs_a_nxt;
      vs_a       <= vs_a_nxt;
    end
  end

  // Alignment stage: timing and source select follow the buffer's one-clock read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      de       <= 1'b0;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
      rd_sel_d <= 1'b0;
    end else begin
      de       <= de_a;
      hsync    <= hs_a;
      vsync    <= vs_a;
      rd_sel_d <= rd_sel;
    end
  end

  assign rgb0_c = '{r: r0, g: g0, b: b0};
  assign rgb1_c = '{r: r1, g: g1, b: b1};

  // Returned data is already registered in the buffer, so the mux adds no further latency.
  always_comb begin
    pix_c = '0;
    if (de) pix_c = rd_sel_d ? rgb1_c : rgb0_c;
  end

  assign pix_r = pix_c.r;
  assign pix_g = pix_c.g;
  assign pix_b = pix_c.b;

endmodule
